// File: rtl/hdmi_tmds_pkg.sv
// hdmi_tmds_pkg: shared constants, types and helpers for the per-channel
// HDMI TMDS encoder (hdmi_tmds_encoder and its stage-1 sub-module).
// Holds the control / video guard-band code words, the symbol and
// running-disparity types, and the stage-1 -> stage-2 pipeline payload.
package hdmi_tmds_pkg;

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned DISP_W = 5;
  localparam int unsigned QM_W   = 9;
  localparam int unsigned N1_W   = 4;

  typedef logic [SYM_W-1:0]         tmds_sym_t;
  typedef logic signed [DISP_W-1:0] tmds_disp_t;

  // Control-period symbols, indexed by {c1, c0}
  localparam tmds_sym_t CTRL_CODE_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_CODE_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_CODE_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_CODE_11 = 10'b1010101011;

  // Video guard-band symbols
  localparam tmds_sym_t GB_CODE_CH02 = 10'b1011001100;
  localparam tmds_sym_t GB_CODE_CH1  = 10'b0100110011;

  // Stage-1 register contents handed to the DC-balance stage
  typedef struct packed {
    logic            de;
    logic            gb;
    logic            c1;
    logic            c0;
    logic [QM_W-1:0] qm;
    logic [N1_W-1:0] n1q;
  } qm_stage_t;

  // Number of set bits in a byte (0..8)
  function automatic logic [N1_W-1:0] popcount8(input logic [7:0] v);
    logic [N1_W-1:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + N1_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/hdmi_tmds_qm_enc.sv
// hdmi_tmds_qm_enc: TMDS stage 1. Builds the transition-minimised 9-bit
// word q_m from the pixel byte, counts the ones in q_m[7:0], and registers
// both together with the delayed qualifiers (de, gb, c0, c1).
// Ports:
//   clk_i, rst_i   pixel clock, synchronous active-high reset
//   data_enable_i  active video qualifier
//   gb_i           video guard-band qualifier
//   c0_i, c1_i     control bits
//   data_i         8-bit pixel component
//   stage_o        registered stage-1 payload (qm_stage_t)
module hdmi_tmds_qm_enc
  import hdmi_tmds_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       data_enable_i,
  input  logic       gb_i,
  input  logic       c0_i,
  input  logic       c1_i,
  input  logic [7:0] data_i,
  output qm_stage_t  stage_o
);

  logic [N1_W-1:0] n1d;
  logic            use_xnor;
  logic [QM_W-1:0] qm;

  // Transition-minimising chain: XNOR when the byte is ones-heavy
  always_comb begin
    n1d      = popcount8(data_i);
    use_xnor = (n1d > N1_W'(4)) || ((n1d == N1_W'(4)) && !data_i[0]);
    qm       = '0;
    qm[0]    = data_i[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ data_i[i]) : (qm[i-1] ^ data_i[i]);
    end
    qm[8] = ~use_xnor;
  end

  // Stage-1 register; reset leaves a control-00 symbol in the pipe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_o <= '0;
    end else begin
      stage_o.de  <= data_enable_i;
      stage_o.gb  <= gb_i;
      stage_o.c1  <= c1_i;
      stage_o.c0  <= c0_i;
      stage_o.qm  <= qm;
      stage_o.n1q <= popcount8(qm[7:0]);
    end
  end

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// hdmi_tmds_encoder: per-channel TMDS encoder, 2-cycle latency.
// Stage 1 (hdmi_tmds_qm_enc) does transition minimisation; stage 2 applies
// DC balancing with a running disparity counter, or substitutes the
// guard-band / control symbol when data enable is low.
// Parameters:
//   CHANNEL        TMDS channel 0..2, selects the video guard-band code
// Ports:
//   clk_i, rst_i   pixel clock, synchronous active-high reset
//   data_enable_i  active video; encode data_i
//   gb_i           video guard-band period
//   c0_i, c1_i     control bits
//   data_i         8-bit pixel component
//   tmds_o         10-bit TMDS symbol, bit 0 transmitted first
// Optional (macro HDMI_TMDS_DISP_MON_EN):
//   disp_o         running disparity after the symbol on tmds_o
//   disp_err_o     sticky flag, disparity magnitude exceeded 10
module hdmi_tmds_encoder
  import hdmi_tmds_pkg::*;
#(
  parameter int unsigned CHANNEL = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       data_enable_i,
  input  logic       gb_i,
  input  logic       c0_i,
  input  logic       c1_i,
  input  logic [7:0] data_i,
  output logic [9:0] tmds_o
`ifdef HDMI_TMDS_DISP_MON_EN
  ,
  output logic [4:0] disp_o,
  output logic [0:0] disp_err_o
`endif
);

  localparam tmds_sym_t GB_CODE = (CHANNEL == 1) ? GB_CODE_CH1 : GB_CODE_CH02;

  qm_stage_t  s1;
  tmds_sym_t  sym_nxt;
  tmds_sym_t  tmds_q;
  tmds_disp_t cnt_q;
  tmds_disp_t cnt_nxt;
  tmds_disp_t n1s;
  tmds_disp_t n0s;

  hdmi_tmds_qm_enc u_qm_enc (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_enable_i (data_enable_i),
    .gb_i          (gb_i),
    .c0_i          (c0_i),
    .c1_i          (c1_i),
    .data_i        (data_i),
    .stage_o       (s1)
  );

  // Stage 2: DC balance for video, fixed symbols otherwise (cnt cleared)
  always_comb begin
    n1s     = tmds_disp_t'({1'b0, s1.n1q});
    n0s     = tmds_disp_t'(8) - n1s;
    sym_nxt = CTRL_CODE_00;
    cnt_nxt = '0;
    if (s1.de) begin
      if ((cnt_q == '0) || (s1.n1q == N1_W'(4))) begin
        sym_nxt = {~s1.qm[8], s1.qm[8], s1.qm[8] ? s1.qm[7:0] : ~s1.qm[7:0]};
        cnt_nxt = s1.qm[8] ? (cnt_q + n1s - n0s) : (cnt_q + n0s - n1s);
      end else if ((!cnt_q[4] && (s1.n1q > N1_W'(4))) ||
                   ( cnt_q[4] && (s1.n1q < N1_W'(4)))) begin
        // cnt is known non-zero here, so !cnt[4] means cnt > 0
        sym_nxt = {1'b1, s1.qm[8], ~s1.qm[7:0]};
        cnt_nxt = cnt_q + (s1.qm[8] ? tmds_disp_t'(2) : tmds_disp_t'(0)) + n0s - n1s;
      end else begin
        sym_nxt = {1'b0, s1.qm[8], s1.qm[7:0]};
        cnt_nxt = cnt_q - (s1.qm[8] ? tmds_disp_t'(0) : tmds_disp_t'(2)) + n1s - n0s;
      end
    end else if (s1.gb) begin
      sym_nxt = GB_CODE;
    end else begin
      case ({s1.c1, s1.c0})
        2'b00:   sym_nxt = CTRL_CODE_00;
        2'b01:   sym_nxt = CTRL_CODE_01;
        2'b10:   sym_nxt = CTRL_CODE_10;
        default: sym_nxt = CTRL_CODE_11;
      endcase
    end
  end

  // Output symbol and running disparity registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmds_q <= CTRL_CODE_00;
      cnt_q  <= '0;
    end else begin
      tmds_q <= sym_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  assign tmds_o = tmds_q;

`ifdef HDMI_TMDS_DISP_MON_EN
  logic disp_err_q;

  // Sticky out-of-range disparity flag, aligned with cnt_q / tmds_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disp_err_q <= 1'b0;
    end else if ((cnt_nxt > tmds_disp_t'(10)) || (cnt_nxt < tmds_disp_t'(-10))) begin
      disp_err_q <= 1'b1;
    end
  end

  assign disp_o     = cnt_q;
  assign disp_err_o = disp_err_q;
`endif

endmodule
